// File: rtl/credit_link_tx.sv
// ---------------------------------------------------------------------------
// credit_link_tx
//
// Credit-based link transmitter for one router output port. It drains a local
// first-word-fall-through flit FIFO onto the inter-router link. A credit
// counter tracks free slots in the downstream input FIFO, so a flit is never
// sent into a full buffer. The far-end FIFO returns one credit per pop.
//
// Parameters
//   DATA_WIDTH    flit width in bits
//   CREDITS       downstream input-FIFO depth (initial and maximum credits)
//   CREDIT_WIDTH  width of the credit counter (derived)
//
// Ports
//   clk            single clock, rising edge
//   reset          synchronous, active-high reset
//   enable         switch-allocator grant for this cycle
//   fifo_empty     local FIFO is empty
//   fifo_dout      head flit of the local FIFO (valid when fifo_empty=0)
//   fifo_pop       pop the local FIFO this cycle (combinational)
//   credit_return  downstream popped one flit this cycle
//   link_valid     link_data carries a flit this cycle (registered)
//   link_data      flit on the link (registered, holds when idle)
//   credits        current credit count (registered)
//   status         FSM state: 0 IDLE, 1 SEND, 2 STALL (registered)
//   credit_err     sticky flag: credit returned while the counter was full
// ---------------------------------------------------------------------------
module credit_link_tx #(
    parameter int DATA_WIDTH   = 64,
    parameter int CREDITS      = 8,
    parameter int CREDIT_WIDTH = $clog2(CREDITS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    fifo_empty,
    input  logic [DATA_WIDTH-1:0]   fifo_dout,
    output logic                    fifo_pop,
    input  logic                    credit_return,
    output logic                    link_valid,
    output logic [DATA_WIDTH-1:0]   link_data,
    output logic [CREDIT_WIDTH-1:0] credits,
    output logic [1:0]              status,
    output logic                    credit_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam logic [CREDIT_WIDTH-1:0] CREDITS_MAX = CREDIT_WIDTH'(CREDITS);
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_ONE  = CREDIT_WIDTH'(1);

    state_t                  state_reg;
    logic [CREDIT_WIDTH-1:0] credits_reg;
    logic [CREDIT_WIDTH-1:0] credits_next;
    logic                    credit_err_reg;
    logic                    credit_err_next;
    logic                    link_valid_reg;
    logic [DATA_WIDTH-1:0]   link_data_reg;
    logic                    have_credit;
    logic                    want_send;
    logic                    send;

    // Send decision uses only the registered credit count, so there is no
    // combinational path from credit_return to fifo_pop.
    always_comb begin
        have_credit = (credits_reg != '0);
        want_send   = enable & ~fifo_empty;
        send        = want_send & have_credit & ~reset;
    end

    assign fifo_pop = send;

    // A send and a return in the same cycle cancel out. A return into a full
    // counter saturates and raises the sticky error.
    always_comb begin
        credits_next    = credits_reg;
        credit_err_next = credit_err_reg;
        case ({send, credit_return})
            2'b10: credits_next = credits_reg - CREDIT_ONE;
            2'b01: begin
                if (credits_reg == CREDITS_MAX) begin
                    credit_err_next = 1'b1;
                end else begin
                    credits_next = credits_reg + CREDIT_ONE;
                end
            end
            default: credits_next = credits_reg;
        endcase
    end

    // Registered FSM and outputs. The state describes the cycle just finished,
    // so it lines up with link_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            credits_reg    <= CREDITS_MAX;
            credit_err_reg <= 1'b0;
            link_valid_reg <= 1'b0;
            link_data_reg  <= '0;
        end else begin
            credits_reg    <= credits_next;
            credit_err_reg <= credit_err_next;
            link_valid_reg <= send;
            if (send) begin
                link_data_reg <= fifo_dout;
            end
            if (want_send && !have_credit) begin
                state_reg <= ST_STALL;
            end else if (send) begin
                state_reg <= ST_SEND;
            end else begin
                state_reg <= ST_IDLE;
            end
        end
    end

    assign link_valid = link_valid_reg;
    assign link_data  = link_data_reg;
    assign credits    = credits_reg;
    assign status     = state_reg;
    assign credit_err = credit_err_reg;

endmodule

// File: tb/tb_credit_link_tx.sv
// ---------------------------------------------------------------------------
// tb_credit_link_tx
//
// Bench for credit_link_tx with CREDITS=4 and 16-bit flits. A table of
// directed vectors walks through reset, burst-to-exhaustion, stall release,
// enable gating, credit overflow and mid-stream reset; a hand-written loop
// covers steady-state send+return; a randomized phase is checked against a
// reference model built from a local FIFO queue and a count of outstanding
// (sent but not yet returned) flits.
// ---------------------------------------------------------------------------
module tb_credit_link_tx;

    localparam int DW = 16;
    localparam int CR = 4;
    localparam int CW = $clog2(CR + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_pop;
    logic          credit_return = 1'b0;
    logic          link_valid;
    logic [DW-1:0] link_data;
    logic [CW-1:0] credits;
    logic [1:0]    status;
    logic          credit_err;

    credit_link_tx #(
        .DATA_WIDTH (DW),
        .CREDITS    (CR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .fifo_empty    (fifo_empty),
        .fifo_dout     (fifo_dout),
        .fifo_pop      (fifo_pop),
        .credit_return (credit_return),
        .link_valid    (link_valid),
        .link_data     (link_data),
        .credits       (credits),
        .status        (status),
        .credit_err    (credit_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One directed vector: inputs for a cycle, the expected combinational pop
    // in that cycle, and the registered outputs after the following edge.
    typedef struct {
        logic          rst;
        logic          en;
        logic          empty;
        logic [DW-1:0] dout;
        logic          cret;
        logic          exp_pop;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic [CW-1:0] exp_cr;
        logic [1:0]    exp_st;
        logic          exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic en, input logic empty,
                       input logic [DW-1:0] dout, input logic cret,
                       input logic p, input logic v, input logic [DW-1:0] d,
                       input logic [CW-1:0] c, input logic [1:0] s, input logic e);
        vec_t x;
        x = '{rst, en, empty, dout, cret, p, v, d, c, s, e};
        vecs.push_back(x);
    endtask

    // Random-phase model state
    logic [DW-1:0] lq[$];
    int            outstanding;
    logic [DW-1:0] last_data;
    logic          exp_pop;
    logic [1:0]    exp_st;
    int            avail;
    logic          cret_now;

    initial begin
        //   rst en emp dout    cr  pop vld data    cred st err
        // reset and idle
        add(1, 0, 1, 16'h0000, 0, 0, 0, 16'h0000, 4, 0, 0);
        add(1, 1, 0, 16'h00AA, 1, 0, 0, 16'h0000, 4, 0, 0);
        add(0, 1, 1, 16'h0000, 0, 0, 0, 16'h0000, 4, 0, 0);
        // burst to exhaustion
        add(0, 1, 0, 16'h00A0, 0, 1, 1, 16'h00A0, 3, 1, 0);
        add(0, 1, 0, 16'h00A1, 0, 1, 1, 16'h00A1, 2, 1, 0);
        add(0, 1, 0, 16'h00A2, 0, 1, 1, 16'h00A2, 1, 1, 0);
        add(0, 1, 0, 16'h00A3, 0, 1, 1, 16'h00A3, 0, 1, 0);
        add(0, 1, 0, 16'h00A4, 0, 0, 0, 16'h00A3, 0, 2, 0);
        add(0, 1, 0, 16'h00A4, 0, 0, 0, 16'h00A3, 0, 2, 0);
        // stall release
        add(0, 1, 0, 16'h00A4, 1, 0, 0, 16'h00A3, 1, 2, 0);
        add(0, 1, 0, 16'h00A4, 0, 1, 1, 16'h00A4, 0, 1, 0);
        add(0, 1, 0, 16'h00A5, 0, 0, 0, 16'h00A4, 0, 2, 0);
        // refill credits with enable low
        add(0, 0, 0, 16'h00A5, 1, 0, 0, 16'h00A4, 1, 0, 0);
        add(0, 0, 0, 16'h00A5, 1, 0, 0, 16'h00A4, 2, 0, 0);
        add(0, 0, 0, 16'h00A5, 1, 0, 0, 16'h00A4, 3, 0, 0);
        add(0, 0, 0, 16'h00A5, 1, 0, 0, 16'h00A4, 4, 0, 0);
        // enable gating at full credits
        add(0, 0, 0, 16'h00A5, 0, 0, 0, 16'h00A4, 4, 0, 0);
        add(0, 0, 0, 16'h00A5, 0, 0, 0, 16'h00A4, 4, 0, 0);
        add(0, 0, 0, 16'h00A5, 0, 0, 0, 16'h00A4, 4, 0, 0);
        add(0, 1, 0, 16'h00A5, 0, 1, 1, 16'h00A5, 3, 1, 0);
        // credit overflow, sticky error
        add(0, 0, 1, 16'h0000, 1, 0, 0, 16'h00A5, 4, 0, 0);
        add(0, 0, 1, 16'h0000, 1, 0, 0, 16'h00A5, 4, 0, 1);
        add(0, 0, 1, 16'h0000, 0, 0, 0, 16'h00A5, 4, 0, 1);
        // mid-stream reset
        add(0, 1, 0, 16'h00B0, 0, 1, 1, 16'h00B0, 3, 1, 1);
        add(1, 1, 0, 16'h00B1, 0, 0, 0, 16'h0000, 4, 0, 0);
        add(0, 1, 0, 16'h00B1, 0, 1, 1, 16'h00B1, 3, 1, 0);
        add(0, 1, 0, 16'h00B2, 0, 1, 1, 16'h00B2, 2, 1, 0);

        foreach (vecs[i]) begin
            reset         = vecs[i].rst;
            enable        = vecs[i].en;
            fifo_empty    = vecs[i].empty;
            fifo_dout     = vecs[i].dout;
            credit_return = vecs[i].cret;
            #1;
            chk($sformatf("vec%0d.pop", i), fifo_pop, vecs[i].exp_pop);
            tick();
            chk($sformatf("vec%0d.valid", i), link_valid, vecs[i].exp_valid);
            chk($sformatf("vec%0d.data", i), link_data, vecs[i].exp_data);
            chk($sformatf("vec%0d.credits", i), credits, vecs[i].exp_cr);
            chk($sformatf("vec%0d.status", i), status, vecs[i].exp_st);
            chk($sformatf("vec%0d.err", i), credit_err, vecs[i].exp_err);
            $display("vec %0d: pop=%0b valid=%0b data=%0h credits=%0d status=%0d err=%0b",
                     i, vecs[i].exp_pop, link_valid, link_data, credits, status, credit_err);
        end

        // Steady state at credits=2: send and return together each cycle.
        for (int i = 0; i < 10; i++) begin
            enable        = 1'b1;
            fifo_empty    = 1'b0;
            fifo_dout     = DW'(16'h00C0 + i);
            credit_return = 1'b1;
            #1;
            chk($sformatf("steady%0d.pop", i), fifo_pop, 1'b1);
            tick();
            chk($sformatf("steady%0d.valid", i), link_valid, 1'b1);
            chk($sformatf("steady%0d.data", i), link_data, 16'h00C0 + i);
            chk($sformatf("steady%0d.credits", i), credits, 2);
            chk($sformatf("steady%0d.err", i), credit_err, 1'b0);
            $display("steady %0d: data=%0h credits=%0d", i, link_data, credits);
        end

        // Randomized phase against the queue/outstanding-count model.
        reset         = 1'b1;
        enable        = 1'b0;
        credit_return = 1'b0;
        fifo_empty    = 1'b1;
        tick();
        reset       = 1'b0;
        outstanding = 0;
        last_data   = '0;
        lq.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(0, 2) != 0 && lq.size() < 8) lq.push_back(DW'($urandom));
            enable     = ($urandom_range(0, 3) != 0);
            fifo_empty = (lq.size() == 0);
            fifo_dout  = fifo_empty ? 16'hDEAD : lq[0];
            cret_now   = (outstanding > 0) && ($urandom_range(0, 2) == 0);
            credit_return = cret_now;
            avail   = CR - outstanding;
            exp_pop = enable && !fifo_empty && (avail != 0);
            exp_st  = (enable && !fifo_empty && avail == 0) ? 2'd2 : (exp_pop ? 2'd1 : 2'd0);
            #1;
            chk($sformatf("rnd%0d.pop", cyc), fifo_pop, exp_pop);
            tick();
            if (exp_pop) begin
                last_data = lq.pop_front();
                outstanding++;
            end
            if (cret_now) outstanding--;
            chk($sformatf("rnd%0d.valid", cyc), link_valid, exp_pop);
            chk($sformatf("rnd%0d.data", cyc), link_data, last_data);
            chk($sformatf("rnd%0d.credits", cyc), credits, CR - outstanding);
            chk($sformatf("rnd%0d.status", cyc), status, exp_st);
            chk($sformatf("rnd%0d.err", cyc), credit_err, 1'b0);
            if (exp_pop) $display("rnd %0d: flit=%0h credits=%0d", cyc, link_data, credits);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/credit_link_tx.md
# credit_link_tx

Credit-based link transmitter for one router output port. It drains a local first-word-fall-through flit FIFO and drives flits onto the inter-router link. It tracks free slots in the downstream router's input FIFO with a credit counter, so flits are never sent into a full buffer. Each transmitter pairs with the input FIFO at the far end of the link; that FIFO returns one credit per pop.

## Interface
- DATA_WIDTH, 64, flit width in bits
- CREDITS, 8, downstream input-FIFO depth; initial and maximum credit count
- CREDIT_WIDTH, $clog2(CREDITS+1), width of the credit counter (derived)

- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  switch-allocator grant; transmission allowed this cycle
- fifo_empty  input  1  local FIFO is empty
- fifo_dout  input  DATA_WIDTH  head flit of local FIFO, valid when fifo_empty=0
- fifo_pop  output  1  pop local FIFO this cycle (combinational)
- credit_return  input  1  downstream popped one flit; one credit per asserted cycle
- link_valid  output  1  link_data carries a flit this cycle (registered)
- link_data  output  DATA_WIDTH  flit on link (registered)
- credits  output  CREDIT_WIDTH  current credit count (registered)
- status  output  2  FSM state: 0 IDLE, 1 SEND, 2 STALL
- credit_err  output  1  sticky flag; a credit was returned while the counter was at CREDITS

There is one clock. Reset is synchronous and active-high.

## Operation
- send = enable & ~fifo_empty & (credits != 0) & ~reset. The credits term uses the registered count.
- fifo_pop = send.
- The pop and the link transfer are the same event. The flit is captured from fifo_dout on the same edge that pops it.
- On each edge: link_valid <= send.
- On each edge, link_data <= fifo_dout when send is high. Otherwise link_data holds its last value; it is not cleared.
- Credit update: credits_next = credits - send + credit_return.
  - send and credit_return in the same cycle leave the count unchanged.
  - credit_return with credits==CREDITS and send=0 keeps credits at CREDITS (saturates) and sets credit_err.
  - The count never goes below 0; send is blocked at 0.
- credit_err stays set until reset.
- FSM, registered, next state from the current cycle's inputs:
  - IDLE: fifo_empty=1 or enable=0.
  - SEND: send=1.
  - STALL: fifo_empty=0, enable=1 and credits==0.
  - Precedence: STALL over SEND over IDLE, as the conditions are mutually exclusive by construction.
  - status reflects the state for the previous cycle, aligned with link_valid.
- Reset behaviour:
  - link_valid=0, link_data=0, credits=CREDITS, status=IDLE, credit_err=0.
  - fifo_pop is forced to 0 while reset is high.
  - credit_return during reset is ignored.
  - Reset asserted mid-stream discards any in-flight accounting. The downstream FIFO is reset by the same signal.

## Timing
- FIFO-to-link latency: 1 cycle. A flit popped in cycle N appears with link_valid=1 in cycle N+1.
- Throughput: 1 flit/cycle while enable=1, the FIFO is non-empty and credits>0.
- Credit-return latency: a credit_return in cycle N is visible in credits, and usable for send, in cycle N+1.
- With CREDITS free slots and no returns, exactly CREDITS back-to-back flits are sent, then send drops.
- Round-trip: sustained full rate requires the downstream pop-to-credit_return loop to be at most CREDITS cycles.
- No combinational path from credit_return to fifo_pop.
- The only combinational outputs are fifo_pop, from enable, fifo_empty, credits and reset.

## Test plan
- Reset then idle (CREDITS=4):
  - During reset: credits=4, link_valid=0, link_data=0, status=0, fifo_pop=0.
  - One cycle after release with fifo_empty=1: all unchanged.
- Burst to exhaustion (CREDITS=4, enable=1, FIFO holds 0xA0..0xA5, no returns):
  - fifo_pop is high for 4 cycles.
  - link_valid is high for 4 cycles carrying 0xA0..0xA3.
  - credits goes 4,3,2,1,0.
  - status then holds 2 (STALL), and 0xA4 stays at the FIFO head.
- Stall release:
  - From the previous end state, assert credit_return for 1 cycle.
  - Next cycle: credits=1, then fifo_pop=1.
  - One cycle later: link_data=0xA4, link_valid=1, credits=0.
- Steady state (credits=2):
  - send and credit_return high together for 10 cycles.
  - credits stays 2; 10 consecutive flits with link_valid=1; credit_err=0.
- Enable gating:
  - FIFO non-empty, credits=4, enable=0 for 3 cycles: fifo_pop=0, link_valid=0, status=0.
  - Re-enable: first flit appears on the next cycle.
- Credit overflow and mid-stream reset:
  - credit_return at credits=4 with send=0: credits stays 4 and credit_err=1, persisting.
  - Then reset for 1 cycle during an active burst: credit_err=0, credits=4, link_valid=0 on the following cycle.
